log2_code_packer: RTL and testbench

- Producer side of the few-shot squared-norm path: accepts a stream of signed BIT_WIDTH embedding values, LANES per beat, and encodes each as a log2 magnitude code.
- Packs COLS codes (SUB_COLS in 4x4 mode) into one vector, presents it with valid/ready, and drives the enable/clear strobes of the downstream squared-log2 sum accumulator.
- Sits between the embedding/weight stream and the prototype bias accumulator.

---
 rtl/log2_code_packer_pkg.sv | 41 ++++
 rtl/log2_code_packer_if.sv | 34 +++
 rtl/log2_code_packer_lane_encoder.sv | 19 +
 rtl/log2_code_packer.sv | 122 ++++++++++++
 tb/tb_log2_code_packer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/log2_code_packer_pkg.sv
// Shared types and helpers for the log2 code packer: FSM states, code width
// and the signed-value to log2-magnitude-code function.
package log2_code_packer_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } pk_state_e;

    typedef struct packed {
        logic [4:0] code;
        logic       zero;
    } log2_code_t;

    function automatic int code_width(input int bit_width);
        return $clog2(bit_width);
    endfunction

    // Magnitude saturates to the largest positive value, so the most negative input
    // encodes like the most positive one.
    function automatic log2_code_t log2_code(input logic signed [31:0] value,
                                             input int bit_width);
        log2_code_t r;
        logic [31:0] mag;
        logic [31:0] sat;
        sat = (32'd1 << (bit_width - 1)) - 32'd1;
        mag = value[31] ? $unsigned(-value) : $unsigned(value);
        if (mag > sat) begin
            mag = sat;
        end
        r.code = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                r.code = 5'(i);
            end
        end
        r.zero = (value == 0);
        return r;
    endfunction

endpackage

// File: rtl/log2_code_packer_if.sv
// Beat input, packed-vector output and accumulator strobes of the log2 code packer.
interface log2_code_packer_if
    import log2_code_packer_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int LANES      = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int CODE_WIDTH = code_width(BIT_WIDTH)
);
    logic                                in_4x4_mode;
    logic                                in_valid;
    logic                                in_ready;
    logic [LANES-1:0][BIT_WIDTH-1:0]     in_data;
    logic                                in_last;
    logic                                out_valid;
    logic                                out_ready;
    logic [COLS-1:0][CODE_WIDTH-1:0]     out_codes;
    logic [COLS-1:0]                     out_zero_mask;
    logic                                out_last;
    logic                                acc_enable;
    logic                                acc_clear;

    modport master (
        output in_4x4_mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_codes, out_zero_mask, out_last,
               acc_enable, acc_clear
    );

    modport slave (
        input  in_4x4_mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_codes, out_zero_mask, out_last,
               acc_enable, acc_clear
    );
endinterface

// File: rtl/log2_code_packer_lane_encoder.sv
// Combinational encoder for one signed lane value: log2 magnitude code and zero flag.
module log2_lane_encoder
    import log2_code_packer_pkg::*;
#(
    parameter  int BIT_WIDTH  = 8,
    localparam int CODE_WIDTH = code_width(BIT_WIDTH)
) (
    input  logic signed [BIT_WIDTH-1:0]  value_i,
    output logic        [CODE_WIDTH-1:0] code_o,
    output logic                         zero_o
);
    log2_code_t enc;

    always_comb begin
        enc    = log2_code({{(32-BIT_WIDTH){value_i[BIT_WIDTH-1]}}, value_i}, BIT_WIDTH);
        code_o = CODE_WIDTH'(enc.code);
        zero_o = enc.zero;
    end
endmodule

// File: rtl/log2_code_packer.sv
// Packs LANES-wide beats of log2 codes into COLS (or SUB_COLS) wide vectors and
// drives the enable/clear strobes of the downstream squared-log2 accumulator.
//
//   state | meaning
//   FILL  | accepting beats, writing codes into slots at beat_idx*LANES
//   HOLD  | vector presented on out_*, waiting for out_ready
module log2_code_packer
    import log2_code_packer_pkg::*;
#(
    parameter int COLS      = 16,
    parameter int SUB_COLS  = 4,
    parameter int BIT_WIDTH = 8,
    parameter int LANES     = 4
) (
    input  logic             clk,
    input  logic             rst,
    log2_code_packer_if.slave bus
);
    localparam int CODE_WIDTH = code_width(BIT_WIDTH);
    localparam int NB_FULL    = COLS / LANES;
    localparam int NB_SUB     = SUB_COLS / LANES;
    localparam int BEAT_W     = (NB_FULL > 1) ? $clog2(NB_FULL) : 1;

    pk_state_e                       state_q, state_d;
    logic [BEAT_W-1:0]               beat_idx_q, beat_idx_d;
    logic                            mode_q, mode_d;
    logic [COLS-1:0][CODE_WIDTH-1:0] codes_q, codes_d;
    logic [COLS-1:0]                 mask_q, mask_d;
    logic                            last_q, last_d;
    logic                            acc_clear_q, acc_clear_d;

    logic [LANES-1:0][CODE_WIDTH-1:0] enc_code;
    logic [LANES-1:0]                 enc_zero;

    logic in_ready, out_valid, accept, handshake, mode_eff, last_beat;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        log2_lane_encoder #(.BIT_WIDTH(BIT_WIDTH)) u_enc (
            .value_i (bus.in_data[l]),
            .code_o  (enc_code[l]),
            .zero_o  (enc_zero[l])
        );
    end

    // Both handshake sides are gated by rst so a held vector is dropped without acc_enable.
    assign in_ready  = (state_q == FILL) && !rst;
    assign out_valid = (state_q == HOLD) && !rst;
    assign accept    = bus.in_valid && in_ready;
    assign handshake = out_valid && bus.out_ready;
    assign mode_eff  = (beat_idx_q == '0) ? bus.in_4x4_mode : mode_q;
    assign last_beat = (int'(beat_idx_q) == ((mode_eff ? NB_SUB : NB_FULL) - 1));

    always_comb begin
        state_d     = state_q;
        beat_idx_d  = beat_idx_q;
        mode_d      = mode_q;
        codes_d     = codes_q;
        mask_d      = mask_q;
        last_d      = last_q;
        acc_clear_d = handshake && last_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (beat_idx_q == '0) begin
                        mode_d = bus.in_4x4_mode;
                    end
                    for (int c = 0; c < COLS; c++) begin
                        if ((c / LANES) == int'(beat_idx_q)) begin
                            codes_d[c] = enc_code[c % LANES];
                            mask_d[c]  = enc_zero[c % LANES];
                        end
                    end
                    beat_idx_d = beat_idx_q + 1'b1;
                    if (last_beat || bus.in_last) begin
                        state_d = HOLD;
                        last_d  = bus.in_last;
                    end
                end
            end
            HOLD: begin
                // Slots are left cleared (code 0, mask 1), so unwritten columns of the
                // next vector come out already padded.
                if (handshake) begin
                    state_d    = FILL;
                    beat_idx_d = '0;
                    codes_d    = '0;
                    mask_d     = '1;
                    last_d     = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            beat_idx_q  <= '0;
            mode_q      <= 1'b0;
            codes_q     <= '0;
            mask_q      <= '1;
            last_q      <= 1'b0;
            acc_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            mode_q      <= mode_d;
            codes_q     <= codes_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            acc_clear_q <= acc_clear_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_codes     = codes_q;
    assign bus.out_zero_mask = mask_q;
    assign bus.out_last      = last_q;
    assign bus.acc_enable    = handshake;
    assign bus.acc_clear     = acc_clear_q;
endmodule

// File: tb/tb_log2_code_packer.sv
// Directed bench for log2_code_packer with a small downstream squared-log2 accumulator.
module tb_log2_code_packer;
    import log2_code_packer_pkg::*;

    localparam int COLS  = 16;
    localparam int LANES = 4;
    localparam int BW    = 8;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    log2_code_packer_if #(.COLS(COLS), .LANES(LANES), .BIT_WIDTH(BW)) bus ();

    log2_code_packer #(.COLS(COLS), .SUB_COLS(4), .BIT_WIDTH(BW), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [COLS-1:0][CW-1:0] exp_codes;
    logic [COLS-1:0]         exp_mask;

    task automatic exp_clear();
        exp_codes = '0;
        exp_mask  = '1;
    endtask

    task automatic exp_put(input int col, input int code, input logic z);
        exp_codes[col] = CW'(code);
        exp_mask[col]  = z;
    endtask

    task automatic chk_vec(input string tag);
        chk({tag, "_codes"}, 64'(bus.out_codes), 64'(exp_codes));
        chk({tag, "_mask"}, 64'(bus.out_zero_mask), 64'(exp_mask));
    endtask

    // Downstream accumulator: sums (2^code)^2 of unmasked columns, read out on clear.
    longint acc_sum  = 0;
    longint acc_read = 0;
    int     en_count = 0;

    function automatic longint vec_sum();
        longint s = 0;
        for (int c = 0; c < COLS; c++) begin
            if (!bus.out_zero_mask[c]) begin
                s += longint'(1) << (2 * int'(bus.out_codes[c]));
            end
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (bus.acc_enable) begin
            en_count <= en_count + 1;
        end
        if (bus.acc_clear) begin
            acc_read <= acc_sum;
            acc_sum  <= 0;
        end else if (bus.acc_enable) begin
            acc_sum <= acc_sum + vec_sum();
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic beat(input int a, input int b, input int c, input int d,
                        input logic last, input logic mode);
        bus.in_valid    = 1'b1;
        bus.in_data     = {8'(d), 8'(c), 8'(b), 8'(a)};
        bus.in_last     = last;
        bus.in_4x4_mode = mode;
        #1 chk("beat_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    int en0;

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.in_4x4_mode = 1'b0;
        bus.out_ready   = 1'b0;
        rst             = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_acc_enable", 64'(bus.acc_enable), 64'd0);
        chk("rst_acc_clear", 64'(bus.acc_clear), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        exp_clear();
        chk_vec("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Full mode, [1,2,4,8] x4, in_last on the 4th beat, no backpressure.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            beat(1, 2, 4, 8, 1'b0, 1'b0);
            chk("t1_fill_out_valid", 64'(bus.out_valid), 64'd0);
        end
        beat(1, 2, 4, 8, 1'b1, 1'b0);
        exp_clear();
        for (int c = 0; c < COLS; c++) exp_put(c, c % 4, 1'b0);
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t1_acc_enable", 64'(bus.acc_enable), 64'd1);
        chk("t1_out_last", 64'(bus.out_last), 64'd1);
        chk_vec("t1");
        @(negedge clk);
        chk("t1_done_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t1_done_acc_enable", 64'(bus.acc_enable), 64'd0);
        chk("t1_acc_clear", 64'(bus.acc_clear), 64'd1);
        chk("t1_done_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("t1_acc_clear_off", 64'(bus.acc_clear), 64'd0);
        chk("t1_sum", 64'(acc_read), 64'd340);

        // Encoding corners as a single early-last beat.
        bus.out_ready = 1'b0;
        beat(0, -1, -128, 127, 1'b1, 1'b0);
        exp_clear();
        exp_put(0, 0, 1'b1);
        exp_put(1, 0, 1'b0);
        exp_put(2, 6, 1'b0);
        exp_put(3, 6, 1'b0);
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_out_last", 64'(bus.out_last), 64'd1);
        chk_vec("t2");
        bus.out_ready = 1'b1;
        #1 chk("t2_acc_enable", 64'(bus.acc_enable), 64'd1);
        @(negedge clk);
        chk("t2_acc_clear", 64'(bus.acc_clear), 64'd1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t2_sum", 64'(acc_read), 64'd8193);

        // 4x4 mode, one beat.
        beat(5, -3, 16, 64, 1'b0, 1'b1);
        exp_clear();
        exp_put(0, 2, 1'b0);
        exp_put(1, 1, 1'b0);
        exp_put(2, 4, 1'b0);
        exp_put(3, 6, 1'b0);
        chk("t3_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t3_out_last", 64'(bus.out_last), 64'd0);
        chk_vec("t3");
        bus.out_ready = 1'b1;
        #1 chk("t3_acc_enable", 64'(bus.acc_enable), 64'd1);
        @(negedge clk);
        chk("t3_acc_clear", 64'(bus.acc_clear), 64'd0);
        chk("t3_done_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Full-mode vector with mode toggled mid-vector, then backpressure.
        beat(1, 1, 1, 1, 1'b0, 1'b0);
        beat(2, 2, 2, 2, 1'b0, 1'b1);
        beat(4, 4, 4, 4, 1'b0, 1'b1);
        chk("t4_mode_ignored", 64'(bus.out_valid), 64'd0);
        beat(-8, -8, -8, -8, 1'b0, 1'b1);
        exp_clear();
        for (int c = 0; c < COLS; c++) exp_put(c, c / 4, 1'b0);
        chk_vec("t4");
        en0 = en_count;
        bus.in_valid = 1'b1;
        bus.in_data  = {4{8'sh7f}};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("t4_hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("t4_hold_acc_enable", 64'(bus.acc_enable), 64'd0);
            chk("t4_hold_codes", 64'(bus.out_codes), 64'(exp_codes));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1 chk("t4_release_acc_enable", 64'(bus.acc_enable), 64'd1);
        @(negedge clk);
        chk("t4_enable_count", 64'(en_count - en0), 64'd1);
        chk("t4_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t4_acc_clear", 64'(bus.acc_clear), 64'd0);
        bus.out_ready = 1'b0;

        // Early in_last on beat 2, full mode.
        beat(1, 1, 1, 1, 1'b0, 1'b0);
        beat(-2, 3, -4, 7, 1'b1, 1'b0);
        exp_clear();
        for (int c = 0; c < 4; c++) exp_put(c, 0, 1'b0);
        exp_put(4, 1, 1'b0);
        exp_put(5, 1, 1'b0);
        exp_put(6, 2, 1'b0);
        exp_put(7, 2, 1'b0);
        chk("t5_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_out_last", 64'(bus.out_last), 64'd1);
        chk_vec("t5");
        bus.out_ready = 1'b1;
        #1 chk("t5_acc_enable", 64'(bus.acc_enable), 64'd1);
        @(negedge clk);
        chk("t5_acc_clear", 64'(bus.acc_clear), 64'd1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_acc_clear_off", 64'(bus.acc_clear), 64'd0);
        chk("t5_sum", 64'(acc_read), 64'd4756);

        // Reset while holding a vector.
        beat(5, -3, 16, 64, 1'b0, 1'b1);
        chk("t6_held", 64'(bus.out_valid), 64'd1);
        en0 = en_count;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #1 chk("t6_rst_acc_enable", 64'(bus.acc_enable), 64'd0);
        @(negedge clk);
        exp_clear();
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t6_acc_enable", 64'(bus.acc_enable), 64'd0);
        chk_vec("t6_rst");
        chk("t6_no_enable", 64'(en_count - en0), 64'd0);
        rst = 1'b0;
        bus.in_4x4_mode = 1'b0;
        @(negedge clk);
        chk("t6_post_in_ready", 64'(bus.in_ready), 64'd1);
        beat(1, 2, 3, 4, 1'b0, 1'b0);
        beat(8, 16, 32, 64, 1'b0, 1'b0);
        beat(-1, -2, -4, -8, 1'b0, 1'b0);
        beat(127, 0, 9, 100, 1'b1, 1'b0);
        exp_clear();
        exp_put(0, 0, 1'b0);  exp_put(1, 1, 1'b0);  exp_put(2, 1, 1'b0);  exp_put(3, 2, 1'b0);
        exp_put(4, 3, 1'b0);  exp_put(5, 4, 1'b0);  exp_put(6, 5, 1'b0);  exp_put(7, 6, 1'b0);
        exp_put(8, 0, 1'b0);  exp_put(9, 1, 1'b0);  exp_put(10, 2, 1'b0); exp_put(11, 3, 1'b0);
        exp_put(12, 6, 1'b0); exp_put(13, 0, 1'b1); exp_put(14, 3, 1'b0); exp_put(15, 6, 1'b0);
        chk("t6_fresh_out_valid", 64'(bus.out_valid), 64'd1);
        chk_vec("t6_fresh");
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_acc_clear", 64'(bus.acc_clear), 64'd1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_sum", 64'(acc_read), 64'd13806);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
